music_voice_allocator: RTL and testbench
========================================

# music_voice_allocator

Shares a small pool of tone-generator voices among the six music keys. Takes the gated per-key press vector from the key controller and assigns each held key to a voice. It runs a per-voice gate/release sequence and steals releasing voices when the pool is exhausted. It sits between key gating and the frequency generator; each voice output drives one generator channel.

## Interface
- NUM_KEYS, 6: number of key requesters
- NUM_VOICES, 3: number of generator channels (1..NUM_KEYS)
- RELEASE_CYCLES, 2_500_000: release-tail length in clocks (50 ms at 50 MHz); must be ≥1
- clock_50Mhz  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- keyPressed  in  NUM_KEYS  1 = key held and allowed to sound (already gated by music box state)
- voiceGate  out  NUM_VOICES  1 = voice in PLAYING
- voiceBusy  out  NUM_VOICES  1 = voice in PLAYING or RELEASE
- voiceStart  out  NUM_VOICES  one-cycle pulse when a voice is newly allocated or retriggered
- voiceKey  out  NUM_VOICES×3  key index owned by each voice; holds last owner when idle
- overflowCount  out  8  saturating count of press edges that found no voice
- debugString  out  32  {overflowCount, 8'b0, voiceBusy padded to 8, voiceGate padded to 8}

## Operation
- Per-voice states: IDLE, PLAYING, RELEASE.
- IDLE→PLAYING on allocation.
- PLAYING→RELEASE when the owned key's keyPressed = 0; release counter loads RELEASE_CYCLES.
- RELEASE counts down by 1 per cycle and goes to IDLE on the cycle the counter reaches 0.
- Retrigger: the owned key returns high while its voice is in RELEASE → PLAYING, voiceStart pulses, counter cleared. All voices retrigger in parallel; this uses no allocation slot.
- Request: key high and not owned by any PLAYING/RELEASE voice.
- At most one allocation per cycle; it serves the lowest-index requesting key.
- Voice choice, in order:
  - lowest-index IDLE voice;
  - else the RELEASE voice with the smallest remaining count (ties → lowest index), which is stolen;
  - else none.
- PLAYING voices are never stolen.
- A request with no voice stays pending and is retried every cycle while the key is held.
- Overflow: a rising edge of keyPressed[k] (registered previous value) in a cycle where no voice can be given to that key → overflowCount += 1, saturating at 255. A press edge that loses only to a lower-index key in the same cycle does not count; it is served next cycle.
- Same-cycle events:
  - release of key A with a request from key B: A's voice enters RELEASE this cycle and is stealable from the next cycle only;
  - a key dropping in the same cycle it would be allocated is not allocated, because the request uses the current keyPressed.

## Timing
- Reset values: all voices IDLE; voiceGate, voiceBusy, voiceStart = 0; voiceKey = 0; overflowCount = 0; previous-key register = 0.
- Keys held through reset produce fresh edges after reset.
- Reset mid-operation aborts all voices in the same cycle; there is no release tail.
- Latency: keyPressed rises at edge n → voiceGate and voiceStart high after edge n+1, when a voice is free.
- Release: keyPressed falls at edge n → voiceGate low after edge n+1; voiceBusy low RELEASE_CYCLES cycles later.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package music_box_pkg holds:
  - the voice_state_t enum {IDLE, PLAYING, RELEASE};
  - MUSIC_KEY_COUNT = 6;
  - KEY_IDX_W = 3.
- Sub-module music_voice_slot implements one voice FSM plus its release counter. It exposes remaining count and state for steal selection.
- The top level holds the edge register, request/priority logic, steal selection and overflow counter.

## Test plan
Benches run with RELEASE_CYCLES = 4 and NUM_VOICES = 3.
- Reset, then keyPressed = 6'b000001 → next cycle voiceGate = 3'b001, voiceKey[0] = 0, voiceStart[0] pulses once.
- Keys 0,1,2 held, then key 3 pressed → no allocation, overflowCount = 1. Key 3 stays held, then key 1 is released → key 1's voice is busy for 4 cycles; on the cycle after it enters RELEASE it is stolen by key 3 (voiceKey = 3, voiceStart pulse).
- Key 2 released for 2 cycles then re-pressed → same voice returns to PLAYING, voiceStart pulses, voiceKey unchanged, no new allocation.
- Keys 0 and 5 rise in the same cycle with all voices free → key 0 goes to voice 0 in cycle n+1, key 5 to voice 1 in cycle n+2, overflowCount = 0.
- Overflow saturation: 300 press edges with the pool full → overflowCount = 255.
- Reset asserted with all voices busy → all outputs 0 next cycle; held keys are reallocated starting the cycle after reset deasserts.

Source files
------------

// File: rtl/music_box_pkg.sv
// music_box_pkg: shared voice state enum and key-index constants for the music box
package music_box_pkg;
  localparam int MUSIC_KEY_COUNT = 6;
  localparam int KEY_IDX_W = 3;
  typedef enum logic [1:0] {IDLE, PLAYING, RELEASE} voice_state_t;
endpackage

// File: rtl/music_voice_slot.sv
// music_voice_slot: one voice FSM (IDLE/PLAYING/RELEASE) with its release-tail counter
//   clk, rst       : clock, synchronous active-high reset
//   i_owner_held   : current keyPressed bit of the key this voice owns
//   i_alloc        : grant this voice to i_alloc_key this cycle (fresh or steal)
//   o_state/o_cnt  : registered state and remaining release count, used for steal choice
//   o_key          : owning key index (kept when idle)
//   o_start        : one-cycle pulse on allocation or retrigger
module music_voice_slot
  import music_box_pkg::*;
#(
  parameter int CNT_W = 22,
  parameter int RELEASE_CYCLES = 2_500_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_owner_held,
  input  logic                 i_alloc,
  input  logic [KEY_IDX_W-1:0] i_alloc_key,
  output voice_state_t         o_state,
  output logic [CNT_W-1:0]     o_cnt,
  output logic [KEY_IDX_W-1:0] o_key,
  output logic                 o_start
);
  voice_state_t r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [KEY_IDX_W-1:0] r_key, w_key;
  logic r_start, w_start;
  always_comb begin
    w_state = r_state;
    w_cnt = r_cnt;
    w_key = r_key;
    w_start = 1'b0;
    if (i_alloc) begin
      w_state = PLAYING;
      w_cnt = '0;
      w_key = i_alloc_key;
      w_start = 1'b1;
    end else begin
      case (r_state)
        PLAYING: if (!i_owner_held) begin
          w_state = RELEASE;
          w_cnt = CNT_W'(RELEASE_CYCLES);
        end
        RELEASE: if (i_owner_held) begin
          w_state = PLAYING;
          w_cnt = '0;
          w_start = 1'b1;
        end else begin
          // the count reaching zero and the return to IDLE share one edge
          w_state = (r_cnt <= CNT_W'(1)) ? IDLE : RELEASE;
          w_cnt = (r_cnt <= CNT_W'(1)) ? '0 : r_cnt - CNT_W'(1);
        end
        default: w_state = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_key <= '0;
      r_start <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt <= w_cnt;
      r_key <= w_key;
      r_start <= w_start;
    end
  end
  assign o_state = r_state;
  assign o_cnt = r_cnt;
  assign o_key = r_key;
  assign o_start = r_start;
endmodule

// File: rtl/music_voice_allocator.sv
// music_voice_allocator: shares a pool of tone voices among the music keys, with release tails and stealing
//   clock_50Mhz, reset : clock, synchronous active-high reset
//   keyPressed         : gated per-key hold vector
//   voiceGate/Busy     : per voice PLAYING / PLAYING-or-RELEASE
//   voiceStart         : per voice pulse on allocation or retrigger
//   voiceKey           : per voice owning key index, 3 bits each
//   overflowCount      : saturating count of press edges that found no voice
//   debugString        : {overflowCount, 8'b0, voiceBusy, voiceGate} in byte fields
module music_voice_allocator
  import music_box_pkg::*;
#(
  parameter int NUM_KEYS = MUSIC_KEY_COUNT,
  parameter int NUM_VOICES = 3,
  parameter int RELEASE_CYCLES = 2_500_000
) (
  input  logic                            clock_50Mhz,
  input  logic                            reset,
  input  logic [NUM_KEYS-1:0]             keyPressed,
  output logic [NUM_VOICES-1:0]           voiceGate,
  output logic [NUM_VOICES-1:0]           voiceBusy,
  output logic [NUM_VOICES-1:0]           voiceStart,
  output logic [NUM_VOICES*KEY_IDX_W-1:0] voiceKey,
  output logic [7:0]                      overflowCount,
  output logic [31:0]                     debugString
);
  localparam int CNT_W = $clog2(RELEASE_CYCLES + 1);
  voice_state_t w_state [NUM_VOICES];
  logic [CNT_W-1:0] w_cnt [NUM_VOICES];
  logic [KEY_IDX_W-1:0] w_key [NUM_VOICES];
  logic [NUM_VOICES-1:0] w_held, w_alloc, w_idle_oh, w_steal_oh;
  logic [NUM_KEYS-1:0] w_owned, w_req, r_prev;
  logic [KEY_IDX_W-1:0] w_req_key;
  logic [CNT_W-1:0] w_best;
  logic w_have_voice;
  logic [8:0] w_sum;
  logic [7:0] r_ovf;
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    assign w_held[g] = keyPressed[w_key[g]];
    music_voice_slot #(.CNT_W(CNT_W), .RELEASE_CYCLES(RELEASE_CYCLES)) u_slot (
      .clk          (clock_50Mhz),
      .rst          (reset),
      .i_owner_held (w_held[g]),
      .i_alloc      (w_alloc[g]),
      .i_alloc_key  (w_req_key),
      .o_state      (w_state[g]),
      .o_cnt        (w_cnt[g]),
      .o_key        (w_key[g]),
      .o_start      (voiceStart[g])
    );
    assign voiceGate[g] = w_state[g] == PLAYING;
    assign voiceBusy[g] = w_state[g] != IDLE;
    assign voiceKey[g*KEY_IDX_W +: KEY_IDX_W] = w_key[g];
  end
  always_comb begin
    w_owned = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (w_state[i] != IDLE) w_owned[w_key[i]] = 1'b1;
    w_req = keyPressed & ~w_owned;
    w_req_key = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--)
      if (w_req[k]) w_req_key = KEY_IDX_W'(k);
    w_idle_oh = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--)
      if (w_state[i] == IDLE) begin
        w_idle_oh = '0;
        w_idle_oh[i] = 1'b1;
      end
    // a releasing voice whose owner is back this cycle retriggers, so it is not a steal candidate
    w_steal_oh = '0;
    w_best = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (w_state[i] == RELEASE && !w_held[i] && (w_steal_oh == '0 || w_cnt[i] < w_best)) begin
        w_steal_oh = '0;
        w_steal_oh[i] = 1'b1;
        w_best = w_cnt[i];
      end
    w_have_voice = |(w_idle_oh | w_steal_oh);
    w_alloc = (|w_req) ? ((|w_idle_oh) ? w_idle_oh : w_steal_oh) : '0;
    // only edges in cycles with no voice at all count; losing to a lower key is just a delay
    w_sum = {1'b0, r_ovf} + 9'($countones(keyPressed & ~r_prev & w_req));
  end
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      r_prev <= '0;
      r_ovf <= '0;
    end else begin
      r_prev <= keyPressed;
      r_ovf <= w_have_voice ? r_ovf : (w_sum[8] ? 8'hFF : w_sum[7:0]);
    end
  end
  assign overflowCount = r_ovf;
  assign debugString = {r_ovf, 8'h00, 8'(voiceBusy), 8'(voiceGate)};
endmodule

// File: tb/tb_music_voice_allocator.sv
// tb_music_voice_allocator: directed scenarios plus random keys checked against a behavioural voice-pool model
module tb_music_voice_allocator;
  localparam int NK = 6;
  localparam int NV = 3;
  localparam int RC = 4;
  logic clk = 1'b0;
  logic rst;
  logic [NK-1:0] keys;
  logic [NV-1:0] gate, busy, start;
  logic [NV*3-1:0] vkey;
  logic [7:0] ovf;
  logic [31:0] dbg;
  int total = 0;
  int bad = 0;
  music_voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .RELEASE_CYCLES(RC)) dut (
    .clock_50Mhz   (clk),
    .reset         (rst),
    .keyPressed    (keys),
    .voiceGate     (gate),
    .voiceBusy     (busy),
    .voiceStart    (start),
    .voiceKey      (vkey),
    .overflowCount (ovf),
    .debugString   (dbg)
  );
  always #5 clk = ~clk;
  // model: mode 0 idle, 1 playing, 2 releasing; rem = release cycles left
  int m_mode [NV];
  int m_rem [NV];
  int m_own [NV];
  bit m_pulse [NV];
  int m_ovf;
  bit [NK-1:0] m_last;
  function automatic void m_reset();
    for (int v = 0; v < NV; v++) begin
      m_mode[v] = 0; m_rem[v] = 0; m_own[v] = 0; m_pulse[v] = 0;
    end
    m_ovf = 0;
    m_last = '0;
  endfunction
  function automatic void m_step(bit [NK-1:0] k);
    int holder [NK];
    int want, pick, best;
    for (int i = 0; i < NK; i++) holder[i] = -1;
    for (int v = 0; v < NV; v++) if (m_mode[v] != 0) holder[m_own[v]] = v;
    want = -1;
    for (int i = 0; i < NK; i++) if (want < 0 && k[i] && holder[i] < 0) want = i;
    pick = -1;
    for (int v = 0; v < NV; v++) if (pick < 0 && m_mode[v] == 0) pick = v;
    if (pick < 0) begin
      best = 1 << 30;
      for (int v = 0; v < NV; v++)
        if (m_mode[v] == 2 && !k[m_own[v]] && m_rem[v] < best) begin pick = v; best = m_rem[v]; end
    end
    if (pick < 0)
      for (int i = 0; i < NK; i++)
        if (k[i] && !m_last[i] && holder[i] < 0 && m_ovf < 255) m_ovf++;
    for (int v = 0; v < NV; v++) begin
      m_pulse[v] = 0;
      if (v == pick && want >= 0) begin
        m_mode[v] = 1; m_rem[v] = 0; m_own[v] = want; m_pulse[v] = 1;
      end else if (m_mode[v] == 1 && !k[m_own[v]]) begin
        m_mode[v] = 2; m_rem[v] = RC;
      end else if (m_mode[v] == 2 && k[m_own[v]]) begin
        m_mode[v] = 1; m_rem[v] = 0; m_pulse[v] = 1;
      end else if (m_mode[v] == 2) begin
        m_rem[v]--;
        if (m_rem[v] == 0) m_mode[v] = 0;
      end
    end
    m_last = k;
  endfunction
  task automatic step(input logic r, input logic [NK-1:0] k);
    rst = r;
    keys = k;
    if (r) m_reset(); else m_step(k);
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    step(1, '0);
    step(1, '1);
    total++;
    if ({gate, busy, start, vkey, ovf, dbg} !== '0) begin
      bad++;
      $display("FAIL reset: got gate=%b busy=%b start=%b key=%h ovf=%0d dbg=%h, want all zero", gate, busy, start, vkey, ovf, dbg);
    end
  endtask
  task automatic test_single();
    step(1, '0);
    step(0, 6'b000001);
    total++;
    if (gate !== 3'b001 || start !== 3'b001 || vkey[2:0] !== 3'd0) begin
      bad++;
      $display("FAIL single_alloc: got gate=%b start=%b key0=%0d, want 001 001 0", gate, start, vkey[2:0]);
    end
    step(0, 6'b000001);
    total++;
    if (start !== 3'b000 || gate !== 3'b001) begin
      bad++;
      $display("FAIL single_pulse: got start=%b gate=%b, want 000 001", start, gate);
    end
  endtask
  task automatic test_overflow_steal();
    step(1, '0);
    step(0, 6'b000001);
    step(0, 6'b000011);
    step(0, 6'b000111);
    step(0, 6'b001111);
    total++;
    if (ovf !== 8'd1 || gate !== 3'b111) begin
      bad++;
      $display("FAIL overflow_one: got ovf=%0d gate=%b, want 1 111", ovf, gate);
    end
    step(0, 6'b001101);
    total++;
    if (gate !== 3'b101 || busy !== 3'b111 || start !== 3'b000) begin
      bad++;
      $display("FAIL release_enter: got gate=%b busy=%b start=%b, want 101 111 000", gate, busy, start);
    end
    step(0, 6'b001101);
    total++;
    if (gate !== 3'b111 || start !== 3'b010 || vkey !== 9'b010_011_000 || ovf !== 8'd1) begin
      bad++;
      $display("FAIL steal: got gate=%b start=%b key=%b ovf=%0d, want 111 010 010011000 1", gate, start, vkey, ovf);
    end
  endtask
  task automatic test_retrigger();
    step(0, 6'b001001);
    step(0, 6'b001001);
    total++;
    if (gate !== 3'b011 || busy !== 3'b111) begin
      bad++;
      $display("FAIL retrig_release: got gate=%b busy=%b, want 011 111", gate, busy);
    end
    step(0, 6'b001101);
    total++;
    if (gate !== 3'b111 || start !== 3'b100 || vkey !== 9'b010_011_000 || ovf !== 8'd1) begin
      bad++;
      $display("FAIL retrigger: got gate=%b start=%b key=%b ovf=%0d, want 111 100 010011000 1", gate, start, vkey, ovf);
    end
  endtask
  task automatic test_back_to_back();
    step(1, '0);
    step(0, 6'b100001);
    total++;
    if (gate !== 3'b001 || start !== 3'b001 || vkey[2:0] !== 3'd0) begin
      bad++;
      $display("FAIL b2b_first: got gate=%b start=%b key0=%0d, want 001 001 0", gate, start, vkey[2:0]);
    end
    step(0, 6'b100001);
    total++;
    if (gate !== 3'b011 || start !== 3'b010 || vkey[5:3] !== 3'd5 || ovf !== 8'd0) begin
      bad++;
      $display("FAIL b2b_second: got gate=%b start=%b key1=%0d ovf=%0d, want 011 010 5 0", gate, start, vkey[5:3], ovf);
    end
  endtask
  task automatic test_saturation();
    step(1, '0);
    step(0, 6'b000001);
    step(0, 6'b000011);
    step(0, 6'b000111);
    for (int i = 0; i < 300; i++) begin
      step(0, 6'b001111);
      step(0, 6'b000111);
    end
    total++;
    if (ovf !== 8'd255 || dbg !== 32'hFF00_0707) begin
      bad++;
      $display("FAIL saturate: got ovf=%0d dbg=%h, want 255 ff000707", ovf, dbg);
    end
  endtask
  task automatic test_reset_busy();
    step(1, 6'b000111);
    total++;
    if ({gate, busy, start, vkey, ovf, dbg} !== '0) begin
      bad++;
      $display("FAIL reset_busy: got gate=%b busy=%b start=%b key=%h ovf=%0d, want all zero", gate, busy, start, vkey, ovf);
    end
    step(0, 6'b000111);
    total++;
    if (gate !== 3'b001 || vkey[2:0] !== 3'd0 || ovf !== 8'd0) begin
      bad++;
      $display("FAIL realloc_first: got gate=%b key0=%0d ovf=%0d, want 001 0 0", gate, vkey[2:0], ovf);
    end
    step(0, 6'b000111);
    step(0, 6'b000111);
    total++;
    if (gate !== 3'b111 || vkey !== 9'b010_001_000 || ovf !== 8'd0) begin
      bad++;
      $display("FAIL realloc_all: got gate=%b key=%b ovf=%0d, want 111 010001000 0", gate, vkey, ovf);
    end
  endtask
  task automatic test_random();
    logic [NK-1:0] k;
    logic [NV-1:0] eg, eb, es;
    logic [NV*3-1:0] ek;
    k = '0;
    step(1, '0);
    for (int c = 0; c < 2000; c++) begin
      k = k ^ NK'($urandom & $urandom);
      step(c == 1000, k);
      for (int v = 0; v < NV; v++) begin
        eg[v] = m_mode[v] == 1;
        eb[v] = m_mode[v] != 0;
        es[v] = m_pulse[v];
        ek[v*3 +: 3] = 3'(m_own[v]);
      end
      total++;
      if ({gate, busy, start, vkey, ovf, dbg} !== {eg, eb, es, ek, 8'(m_ovf), 8'(m_ovf), 8'h00, 8'(eb), 8'(eg)}) begin
        bad++;
        $display("FAIL random c=%0d keys=%b: got g=%b b=%b s=%b k=%b o=%0d d=%h, want g=%b b=%b s=%b k=%b o=%0d",
                 c, k, gate, busy, start, vkey, ovf, dbg, eg, eb, es, ek, m_ovf);
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    keys = '0;
    m_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_overflow_steal();
    test_retrigger();
    test_back_to_back();
    test_saturation();
    test_reset_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
